// File: rtl/cve2_pkg.sv
// Shared definitions for the MAC controller and its execute-side responder.
package cve2_pkg;

  localparam int unsigned MacWidth = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    RESP = 2'd3
  } mac_exec_state_e;

endpackage

// File: rtl/cve2_mac_executor.sv
// EX-stage MAC responder: latches operands, drives the shared multiplier,
// accumulates the product and hands the result to writeback.
module cve2_mac_executor
  import cve2_pkg::*;
#(
  parameter int unsigned Width    = MacWidth,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mac_req_i,
  output logic                mac_ready_o,
  input  logic [Width-1:0]    op_a_i,
  input  logic [Width-1:0]    op_b_i,
  input  logic [Width-1:0]    acc_i,
  input  logic                kill_i,
  output logic                mul_req_o,
  output logic [Width-1:0]    mul_op_a_o,
  output logic [Width-1:0]    mul_op_b_o,
  input  logic                mul_valid_i,
  input  logic [Width-1:0]    mul_result_i,
  output logic [Width-1:0]    result_o,
  output logic                ovf_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] mac_count_o
);

  mac_exec_state_e     state;
  logic [Width-1:0]    op_a_q;
  logic [Width-1:0]    op_b_q;
  logic [Width-1:0]    acc_q;
  logic [Width-1:0]    prod_q;
  logic [Width-1:0]    result_q;
  logic                ovf_q;
  logic [CntWidth-1:0] count_q;
  logic [Width-1:0]    sum;

  assign sum = acc_q + prod_q;

  // Kill aborts from any state without touching the result or the counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else if (kill_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mac_req_i) begin
            op_a_q <= op_a_i;
            op_b_q <= op_b_i;
            acc_q  <= acc_i;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mul_valid_i) begin
            prod_q <= mul_result_i;
            state  <= ADD;
          end
        end
        ADD: begin
          result_q <= sum;
          ovf_q    <= (acc_q[Width-1] == prod_q[Width-1]) && (sum[Width-1] != acc_q[Width-1]);
          state    <= RESP;
        end
        RESP: begin
          if (result_ready_i) begin
            count_q <= count_q + CntWidth'(1);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mac_ready_o    = (state == IDLE);
  assign busy_o         = (state != IDLE);
  assign mul_req_o      = (state == MUL);
  assign result_valid_o = (state == RESP);
  assign mul_op_a_o     = op_a_q;
  assign mul_op_b_o     = op_b_q;
  assign result_o       = result_q;
  assign ovf_o          = ovf_q;
  assign mac_count_o    = count_q;

endmodule

// File: tb/tb_cve2_mac_executor.sv
// Self-checking bench for cve2_mac_executor: directed scenarios plus random
// traffic compared every cycle against a transaction-level model.
module tb_cve2_mac_executor;

  localparam int W  = 32;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          mac_req_i;
  logic          mac_ready_o;
  logic [W-1:0]  op_a_i, op_b_i, acc_i;
  logic          kill_i;
  logic          mul_req_o;
  logic [W-1:0]  mul_op_a_o, mul_op_b_o;
  logic          mul_valid_i;
  logic [W-1:0]  mul_result_i;
  logic [W-1:0]  result_o;
  logic          ovf_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic          busy_o;
  logic [CW-1:0] mac_count_o;

  always #5 clk_i = ~clk_i;

  cve2_mac_executor #(.Width(W), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mac_req_i(mac_req_i), .mac_ready_o(mac_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .acc_i(acc_i),
    .kill_i(kill_i),
    .mul_req_o(mul_req_o), .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .result_o(result_o), .ovf_o(ovf_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .mac_count_o(mac_count_o)
  );

  int passed = 0;
  int total  = 0;

  // Model: one in-flight transaction described by its progress flags.
  bit         m_pending, m_have_prod, m_summed, m_fresh_reset;
  logic [W-1:0] m_a, m_b, m_acc, m_prod, m_res;
  bit         m_ovf;
  int         m_count;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_update();
    longint s;
    if (rst_i) begin
      m_pending = 0; m_have_prod = 0; m_summed = 0; m_fresh_reset = 1;
      m_a = '0; m_b = '0; m_res = '0; m_ovf = 0; m_count = 0;
    end else if (kill_i) begin
      m_pending = 0;
    end else if (!m_pending) begin
      if (mac_req_i) begin
        m_pending = 1; m_have_prod = 0; m_summed = 0; m_fresh_reset = 0;
        m_a = op_a_i; m_b = op_b_i; m_acc = acc_i;
      end
    end else if (!m_have_prod) begin
      if (mul_valid_i) begin
        m_have_prod = 1;
        m_prod = mul_result_i;
      end
    end else if (!m_summed) begin
      m_summed = 1;
      m_res = m_acc + m_prod;
      s = longint'($signed(m_acc)) + longint'($signed(m_prod));
      m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end else if (result_ready_i) begin
      m_pending = 0;
      m_count = (m_count + 1) % (1 << CW);
    end
  endtask

  task automatic compare_all();
    bit exp_valid;
    exp_valid = m_pending && m_summed;
    check("mac_ready", W'(mac_ready_o), W'(!m_pending));
    check("busy", W'(busy_o), W'(m_pending));
    check("mul_req", W'(mul_req_o), W'(m_pending && !m_have_prod));
    check("result_valid", W'(result_valid_o), W'(exp_valid));
    check("mac_count", W'(mac_count_o), W'(m_count));
    if (m_pending && !m_have_prod) begin
      check("mul_op_a", mul_op_a_o, m_a);
      check("mul_op_b", mul_op_b_o, m_b);
    end
    if (exp_valid) begin
      check("result", result_o, m_res);
      check("ovf", W'(ovf_o), W'(m_ovf));
    end
    if (m_fresh_reset) begin
      check("reset_result", result_o, '0);
      check("reset_ovf", W'(ovf_o), '0);
      check("reset_op_a", mul_op_a_o, '0);
      check("reset_op_b", mul_op_b_o, '0);
    end
  endtask

  // The multiplier stand-in returns the product of the model's latched operands.
  task automatic tick();
    mul_result_i = m_a * m_b;
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic quiet();
    rst_i = 0; mac_req_i = 0; kill_i = 0; mul_valid_i = 0; result_ready_i = 0;
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc);
    quiet();
    mac_req_i = 1; op_a_i = a; op_b_i = b; acc_i = acc;
    tick();
    mac_req_i = 0;
  endtask

  task automatic run_to_resp();
    quiet(); mul_valid_i = 1; tick();
    quiet(); tick();
  endtask

  task automatic do_mac(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] acc);
    accept(a, b, acc);
    run_to_resp();
    quiet(); result_ready_i = 1; tick();
    quiet();
  endtask

  int saved;

  initial begin
    quiet();
    op_a_i = '0; op_b_i = '0; acc_i = '0; mul_result_i = '0;
    m_a = '0; m_b = '0; m_acc = '0; m_prod = '0; m_res = '0; m_count = 0;
    rst_i = 1; tick(); tick();
    check("lit_reset_ready", W'(mac_ready_o), 1);
    check("lit_reset_count", W'(mac_count_o), 0);
    quiet();

    // Basic: 3*5+10, valid in cycle 3.
    accept(3, 5, 10);
    run_to_resp();
    check("lit_basic_valid", W'(result_valid_o), 1);
    check("lit_basic_result", result_o, 25);
    check("lit_basic_ovf", W'(ovf_o), 0);
    quiet(); result_ready_i = 1; tick();
    check("lit_basic_count", W'(mac_count_o), 1);

    // Stall: four cycles without mul_valid, operands disturbed after accept.
    accept(7, 6, 100);
    op_a_i = 32'hDEAD; acc_i = 32'h5555;
    for (int i = 0; i < 4; i++) tick();
    check("lit_stall_req", W'(mul_req_o), 1);
    check("lit_stall_opa", mul_op_a_o, 7);
    run_to_resp();
    check("lit_stall_result", result_o, 142);
    quiet(); result_ready_i = 1; tick();

    // Overflow and unsigned wrap.
    accept(1, 1, 32'h7FFF_FFFF);
    run_to_resp();
    check("lit_ovf_result", result_o, 32'h8000_0000);
    check("lit_ovf_flag", W'(ovf_o), 1);
    quiet(); result_ready_i = 1; tick();
    accept(1, 1, 32'hFFFF_FFFF);
    run_to_resp();
    check("lit_wrap_result", result_o, 0);
    check("lit_wrap_flag", W'(ovf_o), 0);

    // Backpressure with a competing request.
    quiet(); mac_req_i = 1; op_a_i = 9; op_b_i = 9; acc_i = 9;
    for (int i = 0; i < 5; i++) tick();
    check("lit_bp_valid", W'(result_valid_o), 1);
    check("lit_bp_ready", W'(mac_ready_o), 0);
    check("lit_bp_result", result_o, 0);
    quiet(); result_ready_i = 1; tick();

    // Kill in each state, coinciding with handshakes where possible.
    saved = m_count;
    accept(2, 3, 4);
    quiet(); kill_i = 1; mul_valid_i = 1; tick();
    check("lit_kill_mul_ready", W'(mac_ready_o), 1);
    accept(2, 3, 4);
    quiet(); mul_valid_i = 1; tick();
    quiet(); kill_i = 1; tick();
    check("lit_kill_add_valid", W'(result_valid_o), 0);
    accept(2, 3, 4);
    run_to_resp();
    quiet(); kill_i = 1; result_ready_i = 1; tick();
    check("lit_kill_resp_count", W'(mac_count_o), W'(saved));
    check("lit_kill_resp_busy", W'(busy_o), 0);
    quiet(); kill_i = 1; mac_req_i = 1; tick();
    check("lit_kill_idle_busy", W'(busy_o), 0);

    // Reset mid-MUL, then counter wrap 3 -> 0.
    accept(11, 12, 13);
    quiet(); rst_i = 1; tick();
    check("lit_rst_mul_req", W'(mul_req_o), 0);
    check("lit_rst_count", W'(mac_count_o), 0);
    quiet();
    for (int i = 0; i < 3; i++) do_mac(i + 1, 2, 5);
    check("lit_count_three", W'(mac_count_o), 3);
    do_mac(4, 4, 4);
    check("lit_count_wrap", W'(mac_count_o), 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst_i          = ($urandom_range(0, 99) == 0);
      kill_i         = ($urandom_range(0, 15) == 0);
      mac_req_i      = $urandom_range(0, 1);
      op_a_i         = $urandom();
      op_b_i         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : $urandom();
      acc_i          = $urandom();
      mul_valid_i    = ($urandom_range(0, 2) == 0);
      result_ready_i = $urandom_range(0, 1);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
